// File: rtl/bpm_packet_sink.sv
// Avalon-ST sink for 166-word BPM frames: checks framing, restores data-word sign and
// double-buffers complete frames for readback over an Avalon-MM CSR slave.
module bpm_packet_sink #(
    parameter int unsigned PKT_WORDS = 166,
    parameter int unsigned HDR_WORDS = 3,
    parameter int unsigned TRL_WORDS = 4
) (
    input  logic        clk_clk,
    input  logic        rst_reset,
    input  logic [31:0] data_in_data,
    input  logic        data_in_valid,
    output logic        data_in_ready,
    input  logic        data_in_startofpacket,
    input  logic        data_in_endofpacket,
    input  logic [1:0]  data_in_empty,
    input  logic [8:0]  csr_address,
    input  logic        csr_read,
    output logic [31:0] csr_readdata,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic        frame_ready
);

    localparam int unsigned RamWords = 2 * PKT_WORDS;
    localparam int unsigned RamAw    = $clog2(RamWords);

    localparam logic [7:0] LastIdx   = 8'(PKT_WORDS - 1);
    localparam logic [7:0] FirstData = 8'(HDR_WORDS);
    // Trailer count includes the last data slot's boundary: data spans HDR..PKT-TRL inclusive.
    localparam logic [7:0] LastData  = 8'(PKT_WORDS - TRL_WORDS);

    localparam logic [8:0] AddrRamEnd = 9'(PKT_WORDS);
    localparam logic [8:0] AddrStatus = 9'd256;
    localparam logic [8:0] AddrCtrl   = 9'd257;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDiscard
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic        wr_bank_q, wr_bank_d;
    logic        buf_valid_q, buf_valid_d;
    logic [15:0] good_q, good_d;
    logic [7:0]  err_q, err_d;
    logic        enable_q, enable_d;
    logic        ready_q;
    logic        frame_ready_q, frame_ready_d;

    logic             accept;
    logic             good_inc, err_inc;
    logic             ctrl_wr, cnt_clear;
    logic             ram_we;
    logic [7:0]       wr_idx;
    logic [RamAw-1:0] ram_waddr, ram_raddr;
    logic [31:0]      ram_wdata;

    logic [31:0] mem [RamWords];
    logic [31:0] ram_q;
    logic        sel_ram_q;
    logic [31:0] reg_rdata, reg_rdata_q;

    assign accept        = data_in_valid & ready_q;
    assign data_in_ready = ready_q;
    assign frame_ready   = frame_ready_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wr_bank_d     = wr_bank_q;
        buf_valid_d   = buf_valid_q;
        frame_ready_d = 1'b0;
        good_inc      = 1'b0;
        err_inc       = 1'b0;
        ram_we        = 1'b0;
        wr_idx        = idx_q;

        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (data_in_startofpacket) begin
                        ram_we  = 1'b1;
                        wr_idx  = 8'd0;
                        idx_d   = 8'd1;
                        state_d = StRecv;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                StRecv: begin
                    if (data_in_startofpacket) begin
                        err_inc = 1'b1;
                        ram_we  = 1'b1;
                        wr_idx  = 8'd0;
                        idx_d   = 8'd1;
                    end else if (data_in_endofpacket) begin
                        if (idx_q == LastIdx && data_in_empty == 2'd0) begin
                            ram_we        = 1'b1;
                            wr_bank_d     = ~wr_bank_q;
                            buf_valid_d   = 1'b1;
                            good_inc      = 1'b1;
                            frame_ready_d = 1'b1;
                        end else begin
                            err_inc = 1'b1;
                        end
                        idx_d   = 8'd0;
                        state_d = StIdle;
                    end else if (idx_q == LastIdx) begin
                        err_inc = 1'b1;
                        idx_d   = 8'd0;
                        state_d = StDiscard;
                    end else begin
                        ram_we = 1'b1;
                        idx_d  = idx_q + 8'd1;
                    end
                end
                StDiscard: begin
                    // A SOP here is a legitimate new frame start; the overrun was already counted.
                    if (data_in_startofpacket) begin
                        ram_we  = 1'b1;
                        wr_idx  = 8'd0;
                        idx_d   = 8'd1;
                        state_d = StRecv;
                    end else if (data_in_endofpacket) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (!enable_q && state_q != StIdle) begin
            state_d = StIdle;
            idx_d   = 8'd0;
        end
    end

    always_comb begin
        ctrl_wr   = csr_write && (csr_address == AddrCtrl);
        cnt_clear = ctrl_wr && csr_writedata[1];
        enable_d  = ctrl_wr ? csr_writedata[0] : enable_q;
        good_d    = cnt_clear ? 16'd0 : good_q + {15'd0, good_inc};
        err_d     = err_q;
        if (cnt_clear) begin
            err_d = 8'd0;
        end else if (err_inc && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_comb begin
        ram_wdata = data_in_data;
        if (wr_idx >= FirstData && wr_idx <= LastData) begin
            ram_wdata = 32'd0 - data_in_data;
        end
        ram_waddr = wr_bank_q ? RamAw'(PKT_WORDS) + RamAw'(wr_idx) : RamAw'(wr_idx);
        ram_raddr = wr_bank_q ? RamAw'(csr_address[7:0]) :
                                RamAw'(PKT_WORDS) + RamAw'(csr_address[7:0]);
    end

    always_comb begin
        reg_rdata = 32'd0;
        if (csr_address == AddrStatus) begin
            reg_rdata = {good_q, err_q, 7'd0, buf_valid_q};
        end else if (csr_address == AddrCtrl) begin
            reg_rdata = {31'd0, enable_q};
        end
    end

    always_ff @(posedge clk_clk or posedge rst_reset) begin
        if (rst_reset) begin
            state_q       <= StIdle;
            idx_q         <= 8'd0;
            wr_bank_q     <= 1'b0;
            buf_valid_q   <= 1'b0;
            good_q        <= 16'd0;
            err_q         <= 8'd0;
            enable_q      <= 1'b1;
            ready_q       <= 1'b0;
            frame_ready_q <= 1'b0;
            sel_ram_q     <= 1'b0;
            reg_rdata_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wr_bank_q     <= wr_bank_d;
            buf_valid_q   <= buf_valid_d;
            good_q        <= good_d;
            err_q         <= err_d;
            enable_q      <= enable_d;
            ready_q       <= enable_d;
            frame_ready_q <= frame_ready_d;
            sel_ram_q     <= csr_read && (csr_address < AddrRamEnd);
            reg_rdata_q   <= csr_read ? reg_rdata : 32'd0;
        end
    end

    // Reads always target the opposite bank from writes, so no read-during-write hazard.
    always_ff @(posedge clk_clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_q <= mem[ram_raddr];
    end

    assign csr_readdata = sel_ram_q ? ram_q : reg_rdata_q;

endmodule

// File: tb/tb_bpm_packet_sink.sv
// Directed plus randomized bench for bpm_packet_sink against a frame-level reference model.
module tb_bpm_packet_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_in_data = '0;
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic        data_in_startofpacket = 1'b0;
    logic        data_in_endofpacket = 1'b0;
    logic [1:0]  data_in_empty = '0;
    logic [8:0]  csr_address = '0;
    logic        csr_read = 1'b0;
    logic [31:0] csr_readdata;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic        frame_ready;

    bpm_packet_sink dut (
        .clk_clk               (clk),
        .rst_reset             (rst),
        .data_in_data          (data_in_data),
        .data_in_valid         (data_in_valid),
        .data_in_ready         (data_in_ready),
        .data_in_startofpacket (data_in_startofpacket),
        .data_in_endofpacket   (data_in_endofpacket),
        .data_in_empty         (data_in_empty),
        .csr_address           (csr_address),
        .csr_read              (csr_read),
        .csr_readdata          (csr_readdata),
        .csr_write             (csr_write),
        .csr_writedata         (csr_writedata),
        .frame_ready           (frame_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int fr_cnt  = 0;

    always @(posedge clk) if (!rst && frame_ready) fr_cnt++;

    // Reference model: frame-level view built from queues.
    int          mode = 0;  // 0 waiting for SOP, 1 collecting, 2 dropping overrun
    logic [31:0] cur[$];
    logic [31:0] exp_frame[166];
    int          exp_good = 0;
    int          exp_err = 0;
    bit          exp_valid = 0;
    int          exp_fr = 0;

    logic [31:0] qd[$];
    bit          qs[$];
    bit          qe[$];
    logic [1:0]  qm[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic err_up();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic commit();
        for (int i = 0; i < 166; i++) begin
            exp_frame[i] = (i >= 3 && i <= 162) ? 32'd0 - cur[i] : cur[i];
        end
        exp_good  = (exp_good + 1) % 65536;
        exp_valid = 1;
        exp_fr++;
    endtask

    task automatic model_beat(input logic [31:0] d, input bit s, input bit e, input logic [1:0] m);
        if (mode == 0) begin
            if (s) begin cur = {d}; mode = 1; end
            else err_up();
        end else if (mode == 1) begin
            if (s) begin err_up(); cur = {d}; end
            else if (e) begin
                if (cur.size() == 165 && m == 2'd0) begin cur.push_back(d); commit(); end
                else err_up();
                mode = 0;
            end else if (cur.size() == 165) begin err_up(); mode = 2; end
            else cur.push_back(d);
        end else begin
            if (s) begin cur = {d}; mode = 1; end
            else if (e) mode = 0;
        end
    endtask

    task automatic add(input logic [31:0] d, input bit s, input bit e, input logic [1:0] m);
        qd.push_back(d); qs.push_back(s); qe.push_back(e); qm.push_back(m);
    endtask

    task automatic build_frame(input int len, input bit rnd, input bit eop_last);
        for (int i = 0; i < len; i++) begin
            add(rnd ? $urandom : 32'(i), i == 0, eop_last && (i == len - 1), 2'd0);
        end
    endtask

    task automatic send_beats(input bit clr_last, input bit gaps);
        for (int i = 0; i < qd.size(); i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                data_in_valid = 1'b0;
                @(posedge clk); #1;
            end
            data_in_data          = qd[i];
            data_in_startofpacket = qs[i];
            data_in_endofpacket   = qe[i];
            data_in_empty         = qm[i];
            data_in_valid         = 1'b1;
            if (clr_last && i == qd.size() - 1) begin
                csr_address   = 9'd257;
                csr_writedata = 32'h3;
                csr_write     = 1'b1;
            end
            @(posedge clk); #1;
            model_beat(qd[i], qs[i], qe[i], qm[i]);
            if (clr_last && i == qd.size() - 1) begin
                exp_good  = 0;
                exp_err   = 0;
                csr_write = 1'b0;
            end
        end
        data_in_valid = 1'b0;
        data_in_startofpacket = 1'b0;
        data_in_endofpacket = 1'b0;
        data_in_empty = 2'd0;
        qd.delete(); qs.delete(); qe.delete(); qm.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic csr_rd(input logic [8:0] a, output logic [31:0] r);
        csr_address = a;
        csr_read    = 1'b1;
        @(posedge clk); #1;
        csr_read = 1'b0;
        r = csr_readdata;
    endtask

    task automatic csr_wr(input logic [8:0] a, input logic [31:0] d);
        csr_address   = a;
        csr_writedata = d;
        csr_write     = 1'b1;
        @(posedge clk); #1;
        csr_write = 1'b0;
    endtask

    task automatic verify(input string tag);
        logic [31:0] r;
        int a;
        csr_rd(9'd256, r);
        check({tag, ".status"}, r, {16'(exp_good), 8'(exp_err), 7'd0, exp_valid});
        check({tag, ".frame_ready_count"}, 32'(fr_cnt), 32'(exp_fr));
        if (exp_valid) begin
            for (int k = 0; k < 4; k++) begin
                a = $urandom_range(165);
                csr_rd(9'(a), r);
                check($sformatf("%s.word%0d", tag, a), r, exp_frame[a]);
            end
        end
    endtask

    logic [31:0] r;
    int kind, len;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset.ready", 32'(data_in_ready), 32'd0);
        check("reset.readdata", csr_readdata, 32'd0);
        check("reset.frame_ready", 32'(frame_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(data_in_ready), 32'd1);
        csr_rd(9'd256, r); check("reset.status", r, 32'h0);
        csr_rd(9'd257, r); check("reset.ctrl", r, 32'h1);

        // Good frame, value = index.
        build_frame(166, 0, 1); send_beats(0, 0);
        check("good.frame_ready_count", 32'(fr_cnt), 32'd1);
        csr_rd(9'd5, r);   check("good.word5", r, 32'hFFFF_FFFB);
        csr_rd(9'd0, r);   check("good.word0", r, 32'd0);
        csr_rd(9'd165, r); check("good.word165", r, 32'd165);
        csr_rd(9'd162, r); check("good.word162", r, 32'd0 - 32'd162);
        csr_rd(9'd163, r); check("good.word163", r, 32'd163);
        csr_rd(9'd256, r); check("good.status", r, 32'h0001_0001);
        csr_rd(9'd200, r); check("unmapped_read", r, 32'd0);

        // Short frame: EOP on word 100.
        build_frame(101, 1, 1); send_beats(0, 0);
        csr_rd(9'd256, r); check("short.status", r, 32'h0001_0101);
        csr_rd(9'd5, r);   check("short.old_word5", r, 32'hFFFF_FFFB);
        check("short.frame_ready_count", 32'(fr_cnt), 32'd1);

        // Long frame then a good one.
        build_frame(170, 1, 1); send_beats(0, 1);
        verify("long");
        build_frame(166, 1, 1); send_beats(0, 1);
        verify("after_long");

        // SOP at word 50 followed by a full frame.
        build_frame(50, 1, 0); build_frame(166, 1, 1); send_beats(0, 0);
        verify("restart");

        // Edge values.
        for (int i = 0; i < 166; i++) begin
            add(i == 10 ? 32'h8000_0000 : (i == 3 ? 32'd0 : $urandom), i == 0, i == 165, 2'd0);
        end
        send_beats(0, 0);
        csr_rd(9'd10, r); check("edge.min_int", r, 32'h8000_0000);
        csr_rd(9'd3, r);  check("edge.zero", r, 32'd0);

        // Randomised mix of frame kinds.
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(6);
            case (kind)
                0: build_frame(166, 1, 1);
                1: begin len = $urandom_range(164, 2); build_frame(len, 1, 1); end
                2: begin len = $urandom_range(175, 167); build_frame(len, 1, 1); end
                3: begin len = $urandom_range(150, 1); build_frame(len, 1, 0);
                         build_frame(166, 1, 1); end
                4: begin
                    for (int j = 0; j < $urandom_range(3, 1); j++) add($urandom, 0, $urandom_range(1), 2'd0);
                    build_frame(166, 1, 1);
                end
                5: begin
                    for (int i = 0; i < 166; i++) add($urandom, i == 0, i == 165, i == 165 ? 2'd2 : 2'd0);
                end
                default: begin
                    len = $urandom_range(172, 166); build_frame(len, 1, 0);
                    build_frame(166, 1, 1);
                end
            endcase
            send_beats(0, 1);
            verify($sformatf("rnd%0d", it));
        end

        // Counter clear coinciding with a good-frame increment.
        build_frame(1, 1, 1);  // stray SOP+EOP short frame: error
        build_frame(166, 1, 1);
        send_beats(1, 0);
        verify("clear");

        // Disable mid-frame.
        build_frame(50, 1, 0); send_beats(0, 0);
        csr_wr(9'd257, 32'h0);
        check("disable.ready_low", 32'(data_in_ready), 32'd0);
        mode = 0;
        csr_rd(9'd257, r); check("disable.ctrl", r, 32'd0);
        csr_wr(9'd257, 32'h1);
        check("enable.ready_high", 32'(data_in_ready), 32'd1);
        build_frame(166, 1, 1); send_beats(0, 0);
        verify("after_disable");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
